// File: rtl/bus_read_sequencer.sv
// Receive side of a set of tri-state registers sharing one data bus.
// Selects one source at a time with an active-low chip-select, lets the bus
// settle, captures the value and hands it downstream over valid/ready.
//
// Handshake: data_valid rises with a captured word and data_out stays stable
// until a Tick edge sees data_valid=1 and data_ready=1; that edge consumes the
// word. data_ready is ignored while data_valid=0, and nothing is consumed on
// edges where Tick=0.
module bus_read_sequencer #(
  parameter int NrOfBits     = 8,
  parameter int NrOfSources  = 4,
  parameter int SettleCycles = 1,
  localparam int SW          = $clog2(NrOfSources)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Tick,
  input  logic                   start,
  input  logic [SW-1:0]          base_sel,
  input  logic [SW:0]            count,
  input  logic [NrOfBits-1:0]    bus_in,
  input  logic                   data_ready,
  output logic [NrOfSources-1:0] cs_n,
  output logic [NrOfBits-1:0]    data_out,
  output logic                   data_valid,
  output logic                   busy,
  output logic                   done,
  output logic [SW-1:0]          cur_sel,
  output logic [1:0]             fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_HOLD   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LIM = 4'(SettleCycles);
  localparam logic [SW-1:0] LAST_IDX = SW'(NrOfSources - 1);

  state_t                 state_q;
  logic [3:0]             settle_q;
  logic [SW:0]            rem_q;
  logic [SW-1:0]          cur_sel_q;
  logic [NrOfSources-1:0] cs_n_q;
  logic [NrOfBits-1:0]    data_out_q;
  logic                   data_valid_q;
  logic                   busy_q;
  logic                   done_q;

  logic [SW-1:0]          next_idx_d;
  logic [SW:0]            rem_dec_d;

  // Active-low one-hot select for source i; out-of-range indices select nothing.
  function automatic logic [NrOfSources-1:0] sel_mask(input logic [SW-1:0] i);
    logic [NrOfSources-1:0] m;
    for (int k = 0; k < NrOfSources; k++) begin
      m[k] = (k != int'(i));
    end
    return m;
  endfunction

  // Next source index (wrapping) and the remaining count after a handshake.
  always_comb begin
    next_idx_d = (cur_sel_q == LAST_IDX) ? '0 : cur_sel_q + 1'b1;
    rem_dec_d  = rem_q - 1'b1;
  end

  // Sequencer FSM with all outputs registered; advances only on Tick edges.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      settle_q     <= '0;
      rem_q        <= '0;
      cur_sel_q    <= '0;
      cs_n_q       <= '1;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (Tick) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (count != '0) begin
              cur_sel_q <= base_sel;
              rem_q     <= count;
              settle_q  <= '0;
              cs_n_q    <= sel_mask(base_sel);
              state_q   <= S_SELECT;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_SELECT: begin
          // Sample while chip-select is still low, then release the bus.
          if (settle_q == SETTLE_LIM) begin
            data_out_q   <= bus_in;
            data_valid_q <= 1'b1;
            cs_n_q       <= '1;
            state_q      <= S_HOLD;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (data_valid_q && data_ready) begin
            data_valid_q <= 1'b0;
            rem_q        <= rem_dec_d;
            if (rem_dec_d == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              // cs_n is all ones here, so selecting the next source never
              // overlaps with the previous one.
              cur_sel_q <= next_idx_d;
              settle_q  <= '0;
              cs_n_q    <= sel_mask(next_idx_d);
              state_q   <= S_SELECT;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cs_n       = cs_n_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cur_sel    = cur_sel_q;
  assign fsm_state  = state_q;

endmodule

// File: doc/bus_read_sequencer.md
Name: bus_read_sequencer

Overview:
- Reads a series of tri-state bus registers that share one data bus, so it is the receive side of those registers.
- Each source drives the bus only while its active-low chip-select is 0, and floats the bus when its chip-select is 1.
- The block drives the chip-select lines one source at a time, waits a fixed settle time, and captures the bus value.
- It delivers each captured word to the downstream consumer through a valid/ready handshake. It sits between the memory/register bank and the compute datapath.

Parameters:
- NrOfBits, 8, width of the shared data bus and of data_out.
- NrOfSources, 4, number of tri-state sources on the bus; also the width of cs_n. Range 2..16.
- SettleCycles, 1, number of extra Tick-qualified cycles that chip-select is held before the bus is sampled. Range 0..15.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Tick  in  1  clock enable; the FSM, counters and handshake advance only on edges where Tick=1.
- start  in  1  request a burst; sampled in IDLE only.
- base_sel  in  SW=$clog2(NrOfSources)  index of the first source in the burst.
- count  in  SW+1  number of words to read; 0 is legal.
- bus_in  in  NrOfBits  shared tri-state data bus.
- data_ready  in  1  consumer accepts data_out.
- cs_n  out  NrOfSources  active-low chip-selects; at most one bit is 0.
- data_out  out  NrOfBits  captured word.
- data_valid  out  1  data_out holds an unconsumed word.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when a burst completes.
- cur_sel  out  SW  index of the source currently addressed or just captured.

Behaviour:
- Reset (asynchronous, effective immediately, including mid-burst):
  - cs_n = all 1s; data_out = 0; data_valid = 0; busy = 0; done = 0; cur_sel = 0.
  - FSM goes to IDLE; the settle counter and remaining-count are cleared.
- All outputs are registered, and there is no combinational path from any input to any output.
- FSM states are IDLE, SELECT, HOLD and DONE. Each transition needs Tick=1 at the rising edge.
- IDLE:
  - If start=1 and count>0: load idx=base_sel, rem=count, settle=0; drive cs_n[base_sel]=0; set cur_sel=base_sel; go to SELECT.
  - If start=1 and count=0: go to DONE without driving any chip-select.
  - start is ignored in every state other than IDLE.
- SELECT:
  - cs_n[idx] is held low; settle increments on each Tick.
  - On the Tick where settle==SettleCycles: capture data_out<=bus_in, set data_valid=1, drive cs_n all 1s, go to HOLD.
  - cs_n is therefore low for exactly SettleCycles+1 Ticks.
- HOLD:
  - cs_n stays all 1s and data_out is stable.
  - Handshake: on a Tick edge with data_valid=1 and data_ready=1, set data_valid=0 and rem=rem-1.
  - If the new rem is 0, go to DONE.
  - Otherwise: idx=(idx+1) mod NrOfSources (wraps from NrOfSources-1 to 0); settle=0; cur_sel=idx; drive cs_n[idx]=0; go to SELECT.
  - The next chip-select asserts at the same edge as the handshake, so there is no idle gap.
- DONE: done=1 for exactly one Tick cycle, then IDLE. busy falls at that same edge.
- data_ready is don't-care when data_valid=0.
- Tick=0: every register holds, including cs_n and data_valid. A held handshake is not consumed.
- count greater than NrOfSources is legal; indices wrap and sources are reread.
- cs_n must never have two bits low, including across the HOLD->SELECT transition and during reset.

Test Plan:
- Defaults, Tick=1, bus model returns 8'hA0+i when cs_n[i]=0 (Z otherwise), base_sel=1, count=2, data_ready=1:
  - cs_n=4'b1101 for 2 cycles, then data_out=8'hA1 with valid.
  - Then cs_n=4'b1011 for 2 cycles, then data_out=8'hA2.
  - done pulses once; busy returns to 0.
- base_sel=3, count=3: read order is A3, A0, A1 (wrap-around); cur_sel sequence is 3, 0, 1.
- data_ready=0 for 5 cycles after the first capture: data_valid stays 1, data_out stays 8'hA1 and cs_n stays 4'b1111 until ready rises. Then the next select starts.
- count=0 with start=1: done pulses the next cycle, cs_n is never low, data_valid stays 0.
- Reset asserted mid-SELECT between edges: cs_n=4'b1111, data_valid=0 and busy=0 immediately (asynchronous). A subsequent start behaves as if fresh.
- Tick toggled 1/0 every cycle with SettleCycles=2: cs_n is low for 3 Tick-qualified cycles (6 clocks). start pulsed while busy is ignored.
